// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
// Central stall/flush controller for a 5-stage IF/ID/EX/MEM/WB pipeline.
// It drives the hold (stall) and clear (refresh) controls of the PC and the
// if_id, id_ex, ex_mem and mem_wb segment registers.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   id_rs/id_rt(+_ren)  ID source registers and whether they are read
//   ex_load, ex_regwen, ex_wreg   EX load flag, GPR write enable, destination
//   ex_div_start        EX holds a divide (level, held while in EX)
//   inst_req/inst_ack   instruction fetch outstanding / returned
//   data_req/data_ack   data access outstanding / completed
//   mem_exc, mem_eret   exception / eret in MEM
//   *_stall             hold PC, if_id, id_ex, ex_mem
//   *_refresh           clear if_id, id_ex, ex_mem, mem_wb
//   redirect            load PC from the exception/eret target
//   div_done            divider result valid this cycle
//   stall_cycles        wrapping count of cycles with if_stall=1
module pipe_hazard_ctrl #(
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_rs_ren,
  input  logic             id_rt_ren,
  input  logic             ex_load,
  input  logic             ex_regwen,
  input  logic [4:0]       ex_wreg,
  input  logic             ex_div_start,
  input  logic             inst_req,
  input  logic             inst_ack,
  input  logic             data_req,
  input  logic             data_ack,
  input  logic             mem_exc,
  input  logic             mem_eret,
  output logic             if_stall,
  output logic             id_stall,
  output logic             ex_stall,
  output logic             mem_stall,
  output logic             if_id_refresh,
  output logic             id_ex_refresh,
  output logic             ex_mem_refresh,
  output logic             mem_wb_refresh,
  output logic             redirect,
  output logic             div_done,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int DCW = (DIV_CYCLES > 2) ? $clog2(DIV_CYCLES) : 1;
  localparam logic [DCW-1:0] DIV_LAST = DCW'(DIV_CYCLES - 1);

  typedef enum logic {
    RUN     = 1'b0,
    DISCARD = 1'b1   // the fetch in flight at flush time is stale; drop it
  } state_t;

  state_t             state_reg;
  logic [DCW-1:0]     div_cnt_reg;
  logic [CNT_W-1:0]   stall_cycles_reg;

  logic               in_run;
  logic               flush;
  logic               dmem_wait;
  logic               div_busy;
  logic               load_use;
  logic               imem_wait;
  logic               discard;

  // Load-use match for each ID source operand (index 0 = rs, 1 = rt).
  logic [1:0][4:0]    src_addr;
  logic [1:0]         src_ren;
  logic [1:0]         src_hit;

  assign src_addr = {id_rt, id_rs};
  assign src_ren  = {id_rt_ren, id_rs_ren};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      assign src_hit[gi] = src_ren[gi] && (src_addr[gi] == ex_wreg);
    end
  endgenerate

  // Every hazard source is gated by reset so nothing escapes during reset.
  assign in_run    = (state_reg == RUN);
  assign flush     = !reset && in_run && (mem_exc || mem_eret);
  assign dmem_wait = !reset && data_req && !data_ack;
  assign div_done  = !reset && ex_div_start && (div_cnt_reg == DIV_LAST);
  assign div_busy  = !reset && ex_div_start && !div_done;
  assign load_use  = !reset && ex_load && ex_regwen && (ex_wreg != 5'd0) && (|src_hit);
  // In DISCARD the outstanding fetch is stale, so the normal IMEM-wait bubble
  // is replaced by the discard handling below.
  assign imem_wait = !reset && in_run && inst_req && !inst_ack;
  assign discard   = !reset && !in_run;

  always_comb begin
    if_stall       = 1'b0;
    id_stall       = 1'b0;
    ex_stall       = 1'b0;
    mem_stall      = 1'b0;
    if_id_refresh  = 1'b0;
    id_ex_refresh  = 1'b0;
    ex_mem_refresh = 1'b0;
    mem_wb_refresh = 1'b0;
    redirect       = 1'b0;
    if (flush) begin
      // An excepting instruction must not commit; eret does.
      redirect       = 1'b1;
      if_id_refresh  = 1'b1;
      id_ex_refresh  = 1'b1;
      ex_mem_refresh = 1'b1;
      mem_wb_refresh = mem_exc;
    end else begin
      // Stalls nest: a stall of a later stage also freezes all earlier ones.
      mem_stall = dmem_wait;
      ex_stall  = dmem_wait || div_busy;
      id_stall  = ex_stall || load_use;
      if_stall  = id_stall || imem_wait || discard;
      // A bubble is only inserted just behind the frozen region; inside a
      // frozen segment it would destroy a held instruction.
      mem_wb_refresh = dmem_wait;
      ex_mem_refresh = div_busy && !mem_stall;
      id_ex_refresh  = load_use && !ex_stall;
      if_id_refresh  = (imem_wait && !id_stall) || (discard && inst_ack);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg        <= RUN;
      div_cnt_reg      <= '0;
      stall_cycles_reg <= '0;
    end else begin
      case (state_reg)
        RUN:     if (flush && inst_req && !inst_ack) state_reg <= DISCARD;
        DISCARD: if (inst_ack) state_reg <= RUN;
        default: state_reg <= RUN;
      endcase

      // The count saturates at DIV_LAST so div_done holds while a DMEM stall
      // keeps EX frozen; it clears as soon as EX moves on.
      if (flush || !ex_div_start || !ex_stall) begin
        div_cnt_reg <= '0;
      end else if (div_cnt_reg != DIV_LAST) begin
        div_cnt_reg <= div_cnt_reg + DCW'(1);
      end

      stall_cycles_reg <= stall_cycles_reg + CNT_W'(if_stall);
    end
  end

  assign stall_cycles = stall_cycles_reg;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: a vector table, hand-written
// multi-cycle sequences and a randomized run against a reference model.
module tb_pipe_hazard_ctrl;

  localparam int DIVC = 4;
  localparam int CW   = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic [4:0]    id_rs, id_rt, ex_wreg;
  logic          id_rs_ren, id_rt_ren, ex_load, ex_regwen, ex_div_start;
  logic          inst_req, inst_ack, data_req, data_ack, mem_exc, mem_eret;
  logic          if_stall, id_stall, ex_stall, mem_stall;
  logic          if_id_refresh, id_ex_refresh, ex_mem_refresh, mem_wb_refresh;
  logic          redirect, div_done;
  logic [CW-1:0] stall_cycles;

  pipe_hazard_ctrl #(.DIV_CYCLES(DIVC), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_rs_ren(id_rs_ren), .id_rt_ren(id_rt_ren),
    .ex_load(ex_load), .ex_regwen(ex_regwen), .ex_wreg(ex_wreg),
    .ex_div_start(ex_div_start),
    .inst_req(inst_req), .inst_ack(inst_ack),
    .data_req(data_req), .data_ack(data_ack),
    .mem_exc(mem_exc), .mem_eret(mem_eret),
    .if_stall(if_stall), .id_stall(id_stall), .ex_stall(ex_stall), .mem_stall(mem_stall),
    .if_id_refresh(if_id_refresh), .id_ex_refresh(id_ex_refresh),
    .ex_mem_refresh(ex_mem_refresh), .mem_wb_refresh(mem_wb_refresh),
    .redirect(redirect), .div_done(div_done), .stall_cycles(stall_cycles)
  );

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       rs_ren;
    logic       rt_ren;
    logic       ld;
    logic       regwen;
    logic [4:0] wreg;
    logic       div;
    logic       ireq;
    logic       iack;
    logic       dreq;
    logic       dack;
    logic       exc;
    logic       eret;
  } stim_t;

  // Output order: {if,id,ex,mem stall, if_id,id_ex,ex_mem,mem_wb refresh, redirect, div_done}
  typedef struct packed {
    stim_t      s;
    logic [9:0] exp;
  } vec_t;

  vec_t tab[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model state.
  bit m_discard;
  int m_div;
  int m_cnt;

  function automatic stim_t mk(input logic [4:0] rs, input logic [4:0] rt, input logic [1:0] ren,
                               input logic ld, input logic rw, input logic [4:0] wr, input logic dv,
                               input logic [1:0] im, input logic [1:0] dm, input logic [1:0] fl);
    stim_t t;
    t.rs = rs; t.rt = rt; t.rs_ren = ren[1]; t.rt_ren = ren[0];
    t.ld = ld; t.regwen = rw; t.wreg = wr; t.div = dv;
    t.ireq = im[1]; t.iack = im[0]; t.dreq = dm[1]; t.dack = dm[0];
    t.exc = fl[1]; t.eret = fl[0];
    return t;
  endfunction

  // Model: each hazard freezes a prefix of the pipeline of some depth
  // (1 = PC only ... 4 = up to ex_mem). The deepest active hazard wins and its
  // bubble goes into the first segment past the frozen region.
  function automatic logic [9:0] model_out(input stim_t s, input logic rst);
    logic [9:0] o;
    int d;
    bit done, dmem, dbusy, lu, imem;
    o = '0;
    if (rst) return o;
    done = s.div && (m_div == DIVC - 1);
    if (!m_discard && (s.exc || s.eret)) begin
      o = {4'b0000, 3'b111, s.exc, 1'b1, done};
      return o;
    end
    dmem  = s.dreq && !s.dack;
    dbusy = s.div && !done;
    lu    = s.ld && s.regwen && (s.wreg != 5'd0) &&
            ((s.rs_ren && s.rs == s.wreg) || (s.rt_ren && s.rt == s.wreg));
    imem  = !m_discard && s.ireq && !s.iack;
    d = 0;
    if (imem || m_discard) d = 1;
    if (lu)    d = 2;
    if (dbusy) d = 3;
    if (dmem)  d = 4;
    o[9] = (d >= 1);
    o[8] = (d >= 2);
    o[7] = (d >= 3);
    o[6] = (d >= 4);
    if (d >= 2 || (d == 1 && imem)) o[6-d] = 1'b1;
    if (m_discard && s.iack) o[5] = 1'b1;
    o[0] = done;
    return o;
  endfunction

  task automatic model_step(input stim_t s, input logic rst);
    logic [9:0] o;
    bit fl;
    o = model_out(s, rst);
    if (rst) begin
      m_discard = 0; m_div = 0; m_cnt = 0;
      return;
    end
    fl = !m_discard && (s.exc || s.eret);
    if (fl && s.ireq && !s.iack) m_discard = 1;
    else if (m_discard && s.iack) m_discard = 0;
    if (fl || !s.div || !o[7]) m_div = 0;
    else if (m_div < DIVC - 1) m_div = m_div + 1;
    m_cnt = (m_cnt + int'(o[9])) % (1 << CW);
  endtask

  task automatic drive(input stim_t s, input logic rst);
    reset = rst;
    id_rs = s.rs; id_rt = s.rt; id_rs_ren = s.rs_ren; id_rt_ren = s.rt_ren;
    ex_load = s.ld; ex_regwen = s.regwen; ex_wreg = s.wreg; ex_div_start = s.div;
    inst_req = s.ireq; inst_ack = s.iack; data_req = s.dreq; data_ack = s.dack;
    mem_exc = s.exc; mem_eret = s.eret;
  endtask

  // One transaction: drive, compare at the falling edge, advance the model.
  task automatic run_cycle(input stim_t s, input logic rst, input bit use_tab,
                           input logic [9:0] texp, input string tag);
    logic [9:0] exp, act;
    drive(s, rst);
    @(negedge clk);
    exp = use_tab ? texp : model_out(s, rst);
    act = {if_stall, id_stall, ex_stall, mem_stall, if_id_refresh, id_ex_refresh,
           ex_mem_refresh, mem_wb_refresh, redirect, div_done};
    $display("[TB] %s rst=%0b out=%b exp=%b cnt=%0d", tag, rst, act, exp, stall_cycles);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s outputs: got %b required %b", tag, act, exp);
    end
    tests++;
    if (stall_cycles !== CW'(m_cnt)) begin
      fails++;
      $display("FAIL %s stall_cycles: got %0d required %0d", tag, stall_cycles, m_cnt);
    end
    model_step(s, rst);
    @(posedge clk);
    #1;
  endtask

  task automatic check_cnt(input string tag, input int req);
    tests++;
    if (stall_cycles !== CW'(req)) begin
      fails++;
      $display("FAIL %s: stall_cycles got %0d required %0d", tag, stall_cycles, req);
    end
  endtask

  task automatic add(input stim_t s, input logic [9:0] e);
    vec_t v;
    v.s = s; v.exp = e;
    tab.push_back(v);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    stim_t idle, s;
    idle = mk(0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00);

    // Initial reset edge, then a checked reset cycle.
    drive(idle, 1'b1);
    @(posedge clk); #1;
    model_step(idle, 1'b1);
    run_cycle(mk(5, 5, 2'b11, 1, 1, 5, 1, 2'b10, 2'b10, 2'b10), 1'b1, 1, 10'b0, "reset_state");

    // Single-cycle vector table (FSM in RUN, divider idle before each entry).
    add(idle,                                                   10'b0000_0000_00);
    add(mk(5, 0, 2'b10, 1, 1, 5, 0, 2'b00, 2'b00, 2'b00),     10'b1100_0100_00);
    add(mk(0, 0, 2'b10, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00),     10'b0000_0000_00);
    add(mk(5, 0, 2'b10, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00),     10'b0000_0000_00);
    add(mk(0, 7, 2'b01, 1, 1, 7, 0, 2'b00, 2'b00, 2'b00),     10'b1100_0100_00);
    add(mk(5, 0, 2'b00, 1, 1, 5, 0, 2'b00, 2'b00, 2'b00),     10'b0000_0000_00);
    add(mk(5, 0, 2'b10, 1, 0, 5, 0, 2'b00, 2'b00, 2'b00),     10'b0000_0000_00);
    add(mk(5, 0, 2'b10, 0, 1, 5, 0, 2'b00, 2'b00, 2'b00),     10'b0000_0000_00);
    add(mk(0, 0, 2'b00, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00),     10'b1000_1000_00);
    add(mk(0, 0, 2'b00, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00),     10'b0000_0000_00);
    add(mk(5, 0, 2'b10, 1, 1, 5, 0, 2'b10, 2'b00, 2'b00),     10'b1100_0100_00);
    add(mk(0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00),     10'b1111_0001_00);
    add(mk(0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b11, 2'b00),     10'b0000_0000_00);
    add(mk(5, 0, 2'b10, 1, 1, 5, 0, 2'b10, 2'b10, 2'b00),     10'b1111_0001_00);
    add(mk(0, 0, 2'b00, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00),     10'b1110_0010_00);
    add(idle,                                                   10'b0000_0000_00);
    add(mk(0, 0, 2'b00, 0, 0, 0, 1, 2'b00, 2'b10, 2'b00),     10'b1111_0001_00);
    add(idle,                                                   10'b0000_0000_00);
    add(mk(5, 0, 2'b10, 1, 1, 5, 1, 2'b00, 2'b00, 2'b00),     10'b1110_0010_00);
    add(idle,                                                   10'b0000_0000_00);
    add(mk(0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 2'b01),     10'b0000_1110_10);
    add(mk(5, 0, 2'b10, 1, 1, 5, 0, 2'b00, 2'b10, 2'b10),     10'b0000_1111_10);
    add(idle,                                                   10'b0000_0000_00);
    for (int i = 0; i < tab.size(); i++) begin
      run_cycle(tab[i].s, 1'b0, 1, tab[i].exp, $sformatf("vec%0d", i));
    end

    // Isolated divide: three stall cycles, done in the fourth.
    run_cycle(idle, 1'b1, 1, 10'b0, "div_reset");
    s = mk(0, 0, 2'b00, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00);
    for (int c = 0; c < 3; c++) run_cycle(s, 1'b0, 1, 10'b1110_0010_00, $sformatf("div_c%0d", c));
    run_cycle(s, 1'b0, 1, 10'b0000_0000_01, "div_c3");
    check_cnt("div_stall_count", 3);
    run_cycle(idle, 1'b0, 1, 10'b0, "div_after");

    // DMEM wait for 6 cycles overlapping a divide.
    s = mk(0, 0, 2'b00, 0, 0, 0, 1, 2'b00, 2'b10, 2'b00);
    for (int c = 0; c < 3; c++) run_cycle(s, 1'b0, 1, 10'b1111_0001_00, $sformatf("divdm_c%0d", c));
    for (int c = 3; c < 6; c++) run_cycle(s, 1'b0, 1, 10'b1111_0001_01, $sformatf("divdm_c%0d", c));
    s.dreq = 1'b0;
    run_cycle(s, 1'b0, 1, 10'b0000_0000_01, "divdm_release");
    run_cycle(idle, 1'b0, 1, 10'b0, "divdm_after");

    // Exception with a pending fetch, then DISCARD until the ack.
    run_cycle(mk(0, 0, 2'b00, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10), 1'b0, 1, 10'b0000_1111_10, "exc_flush");
    run_cycle(mk(0, 0, 2'b00, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00), 1'b0, 1, 10'b1000_0000_00, "discard_wait");
    run_cycle(mk(0, 0, 2'b00, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10), 1'b0, 1, 10'b1000_0000_00, "discard_exc_ign");
    run_cycle(mk(0, 0, 2'b00, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00), 1'b0, 1, 10'b1000_1000_00, "discard_ack");
    run_cycle(mk(0, 0, 2'b00, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00), 1'b0, 1, 10'b1000_1000_00, "back_in_run");
    run_cycle(idle, 1'b0, 1, 10'b0, "exc_after");

    // eret without an outstanding fetch stays in RUN.
    run_cycle(mk(0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 2'b01), 1'b0, 1, 10'b0000_1110_10, "eret");
    run_cycle(mk(0, 0, 2'b00, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00), 1'b0, 1, 10'b1000_1000_00, "eret_still_run");

    // Counter wrap: 17 stall cycles on a 4-bit counter.
    run_cycle(idle, 1'b1, 1, 10'b0, "wrap_reset");
    s = mk(0, 0, 2'b00, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00);
    for (int c = 0; c < 17; c++) run_cycle(s, 1'b0, 1, 10'b1000_1000_00, $sformatf("wrap_c%0d", c));
    check_cnt("wrap_count", 1);

    // Reset while in DISCARD with a divide in progress.
    run_cycle(mk(0, 0, 2'b00, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10), 1'b0, 1, 10'b0000_1111_10, "rst_flush");
    s = mk(0, 0, 2'b00, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00);
    run_cycle(s, 1'b0, 1, 10'b1110_0010_00, "rst_discard_div0");
    run_cycle(s, 1'b0, 1, 10'b1110_0010_00, "rst_discard_div1");
    run_cycle(mk(0, 0, 2'b00, 0, 0, 0, 1, 2'b10, 2'b10, 2'b10), 1'b1, 1, 10'b0, "rst_in_discard");
    check_cnt("rst_count_clear", 0);
    run_cycle(mk(0, 0, 2'b00, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00), 1'b0, 1, 10'b1000_1000_00, "rst_run");
    s = mk(0, 0, 2'b00, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00);
    for (int c = 0; c < 3; c++) run_cycle(s, 1'b0, 1, 10'b1110_0010_00, $sformatf("rst_div_c%0d", c));
    run_cycle(s, 1'b0, 1, 10'b0000_0000_01, "rst_div_done");
    run_cycle(idle, 1'b0, 1, 10'b0, "rst_after");

    // Randomized run against the reference model.
    s = idle;
    for (int n = 0; n < 2000; n++) begin
      logic rst;
      s.rs     = 5'($urandom_range(0, 3));
      s.rt     = 5'($urandom_range(0, 3));
      s.wreg   = 5'($urandom_range(0, 3));
      s.rs_ren = 1'($urandom_range(0, 1));
      s.rt_ren = 1'($urandom_range(0, 1));
      s.ld     = 1'($urandom_range(0, 1));
      s.regwen = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) s.div = ~s.div;
      if ($urandom_range(0, 3) == 0) s.ireq = ~s.ireq;
      s.iack   = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 3) == 0) s.dreq = ~s.dreq;
      s.dack   = ($urandom_range(0, 2) == 0);
      s.exc    = ($urandom_range(0, 15) == 0);
      s.eret   = ($urandom_range(0, 15) == 0);
      rst      = ($urandom_range(0, 63) == 0);
      run_cycle(s, rst, 0, 10'b0, $sformatf("rnd%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
